// File: rtl/bcd_countdown_timer_if.sv
// Button/switch strobes into the countdown timer and its display/status outputs.
interface bcd_countdown_timer_if;
    logic        set_mode_i;
    logic        select_i;
    logic        up_i;
    logic        down_i;
    logic        clear_i;
    logic [31:0] digits_o;
    logic        blink_sec_o;
    logic        blink_min_o;
    logic        blink_hr_o;
    logic        running_o;
    logic        alarm_o;

    modport master (
        output set_mode_i, select_i, up_i, down_i, clear_i,
        input  digits_o, blink_sec_o, blink_min_o, blink_hr_o, running_o, alarm_o
    );

    modport slave (
        input  set_mode_i, select_i, up_i, down_i, clear_i,
        output digits_o, blink_sec_o, blink_min_o, blink_hr_o, running_o, alarm_o
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD hh:mm:ss.cc countdown timer: field-by-field set mode, run/pause, expiry
// alarm and automatic reload of the last programmed hh:mm:ss.
module bcd_countdown_timer #(
    parameter int TICK_DIV    = 500000,
    parameter int BLINK_TICKS = 25,
    parameter int HOUR_MAX    = 23,
    parameter int ALARM_TICKS = 500
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bcd_countdown_timer_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_TICKS + 1);
    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_TICKS - 1);
    localparam logic [AW-1:0] ALARM_LAST   = AW'(ALARM_TICKS - 1);
    localparam logic [7:0]    HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

    typedef enum logic [1:0] {ST_SET, ST_PAUSED, ST_RUN, ST_EXPIRED} state_t;
    typedef enum logic [1:0] {FLD_SEC, FLD_MIN, FLD_HR} field_t;

    state_t        state_q, state_d;
    field_t        field_q, field_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic [7:0]    cc_q, cc_d, ss_q, ss_d, mm_q, mm_d, hh_q, hh_d;
    logic [7:0]    pre_ss_q, pre_ss_d, pre_mm_q, pre_mm_d, pre_hh_q, pre_hh_d;
    logic          running_q, running_d, alarm_q, alarm_d;
    logic          blink_sec_q, blink_sec_d, blink_min_q, blink_min_d;
    logic          blink_hr_q, blink_hr_d;

    logic          tick;
    logic          count_zero;
    logic [7:0]    dec_cc, dec_ss, dec_mm, dec_hh;
    logic          dec_zero;
    logic          any_press;

    // Two-digit BCD step with wrap between 00 and max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == 8'h00)
            r = max_v;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    always_comb begin
        tick          = (presc_q == PRESC_LAST);
        presc_d       = tick ? '0 : presc_q + PW'(1);
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Borrow chain for one centisecond off the running count.
    always_comb begin
        dec_cc = bcd_dec(cc_q, 8'h99);
        dec_ss = ss_q;
        dec_mm = mm_q;
        dec_hh = hh_q;
        if (cc_q == 8'h00) begin
            dec_ss = bcd_dec(ss_q, 8'h59);
            if (ss_q == 8'h00) begin
                dec_mm = bcd_dec(mm_q, 8'h59);
                if (mm_q == 8'h00)
                    dec_hh = bcd_dec(hh_q, HOUR_MAX_BCD);
            end
        end
        dec_zero   = ({dec_hh, dec_mm, dec_ss, dec_cc} == 32'h0);
        count_zero = ({hh_q, mm_q, ss_q, cc_q} == 32'h0);
        any_press  = bus.select_i | bus.up_i | bus.down_i | bus.clear_i;
    end

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        cc_d        = cc_q;
        ss_d        = ss_q;
        mm_d        = mm_q;
        hh_d        = hh_q;
        pre_ss_d    = pre_ss_q;
        pre_mm_d    = pre_mm_q;
        pre_hh_d    = pre_hh_q;
        alarm_cnt_d = '0;

        if (state_q == ST_SET) begin
            pre_ss_d = ss_q;
            pre_mm_d = mm_q;
            pre_hh_d = hh_q;
        end

        if (bus.set_mode_i) begin
            state_d = ST_SET;
            if (state_q != ST_SET) begin
                cc_d = 8'h00;
            end else if (bus.clear_i) begin
                ss_d = 8'h00;
                mm_d = 8'h00;
                hh_d = 8'h00;
            end else if (bus.select_i) begin
                case (field_q)
                    FLD_SEC: field_d = FLD_MIN;
                    FLD_MIN: field_d = FLD_HR;
                    default: field_d = FLD_SEC;
                endcase
            end else if (bus.up_i && !bus.down_i) begin
                case (field_q)
                    FLD_SEC: ss_d = bcd_inc(ss_q, 8'h59);
                    FLD_MIN: mm_d = bcd_inc(mm_q, 8'h59);
                    default: hh_d = bcd_inc(hh_q, HOUR_MAX_BCD);
                endcase
            end else if (bus.down_i && !bus.up_i) begin
                case (field_q)
                    FLD_SEC: ss_d = bcd_dec(ss_q, 8'h59);
                    FLD_MIN: mm_d = bcd_dec(mm_q, 8'h59);
                    default: hh_d = bcd_dec(hh_q, HOUR_MAX_BCD);
                endcase
            end
        end else begin
            case (state_q)
                ST_SET: begin
                    state_d = ST_PAUSED;
                end
                ST_PAUSED: begin
                    if (bus.clear_i) begin
                        {hh_d, mm_d, ss_d, cc_d} = 32'h0;
                    end else if (bus.select_i && !count_zero) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.clear_i) begin
                        {hh_d, mm_d, ss_d, cc_d} = 32'h0;
                        state_d = ST_PAUSED;
                    end else if (bus.select_i) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        {hh_d, mm_d, ss_d, cc_d} = {dec_hh, dec_mm, dec_ss, dec_cc};
                        if (dec_zero)
                            state_d = ST_EXPIRED;
                    end
                end
                default: begin
                    // Any button or a full alarm period restores the programmed value.
                    if (any_press || (tick && alarm_cnt_q == ALARM_LAST)) begin
                        state_d = ST_PAUSED;
                        {hh_d, mm_d, ss_d, cc_d} = {pre_hh_q, pre_mm_q, pre_ss_q, 8'h00};
                    end else begin
                        alarm_cnt_d = tick ? alarm_cnt_q + AW'(1) : alarm_cnt_q;
                    end
                end
            endcase
        end
    end

    always_comb begin
        running_d   = (state_d == ST_RUN);
        alarm_d     = (state_d == ST_EXPIRED);
        blink_sec_d = blink_phase_d &
                      (alarm_d || (state_d == ST_SET && field_d == FLD_SEC));
        blink_min_d = blink_phase_d &
                      (alarm_d || (state_d == ST_SET && field_d == FLD_MIN));
        blink_hr_d  = blink_phase_d &
                      (alarm_d || (state_d == ST_SET && field_d == FLD_HR));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_PAUSED;
            field_q       <= FLD_SEC;
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            alarm_cnt_q   <= '0;
            cc_q          <= 8'h00;
            ss_q          <= 8'h00;
            mm_q          <= 8'h00;
            hh_q          <= 8'h00;
            pre_ss_q      <= 8'h00;
            pre_mm_q      <= 8'h00;
            pre_hh_q      <= 8'h00;
            running_q     <= 1'b0;
            alarm_q       <= 1'b0;
            blink_sec_q   <= 1'b0;
            blink_min_q   <= 1'b0;
            blink_hr_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            field_q       <= field_d;
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            alarm_cnt_q   <= alarm_cnt_d;
            cc_q          <= cc_d;
            ss_q          <= ss_d;
            mm_q          <= mm_d;
            hh_q          <= hh_d;
            pre_ss_q      <= pre_ss_d;
            pre_mm_q      <= pre_mm_d;
            pre_hh_q      <= pre_hh_d;
            running_q     <= running_d;
            alarm_q       <= alarm_d;
            blink_sec_q   <= blink_sec_d;
            blink_min_q   <= blink_min_d;
            blink_hr_q    <= blink_hr_d;
        end
    end

    assign bus.digits_o    = {hh_q, mm_q, ss_q, cc_q};
    assign bus.running_o   = running_q;
    assign bus.alarm_o     = alarm_q;
    assign bus.blink_sec_o = blink_sec_q;
    assign bus.blink_min_o = blink_min_q;
    assign bus.blink_hr_o  = blink_hr_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random button traffic,
// checked every cycle against a centisecond-integer reference model.
module tb_bcd_countdown_timer;
    localparam int TICK_DIV    = 2;
    localparam int BLINK_TICKS = 2;
    localparam int HOUR_MAX    = 23;
    localparam int ALARM_TICKS = 10;

    localparam int M_SET     = 0;
    localparam int M_PAUSED  = 1;
    localparam int M_RUN     = 2;
    localparam int M_EXPIRED = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sm_level = 1'b0;

    bcd_countdown_timer_if bus ();

    bcd_countdown_timer #(
        .TICK_DIV   (TICK_DIV),
        .BLINK_TICKS(BLINK_TICKS),
        .HOUR_MAX   (HOUR_MAX),
        .ALARM_TICKS(ALARM_TICKS)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: count held as total centiseconds, preload as seconds.
    int m_state = M_PAUSED;
    int m_field = 0;
    int m_cs    = 0;
    int m_pre   = 0;
    int m_cyc   = 0;
    int m_ticks = 0;
    int m_acnt  = 0;

    function automatic logic [31:0] to_digits(input int cs);
        int hh, mm, ss, cc;
        hh = cs / 360000;
        mm = (cs / 6000) % 60;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [31:0] exp_flags();
        logic phase, exp_st;
        phase  = ((m_ticks / BLINK_TICKS) % 2) == 1;
        exp_st = (m_state == M_EXPIRED);
        return {27'd0, m_state == M_RUN, exp_st,
                phase && (exp_st || (m_state == M_SET && m_field == 2)),
                phase && (exp_st || (m_state == M_SET && m_field == 1)),
                phase && (exp_st || (m_state == M_SET && m_field == 0))};
    endfunction

    task automatic model_step(input logic r, input logic sm, input logic sel,
                              input logic up, input logic dn, input logic clr);
        int old_state, old_cs, hh, mm, ss, cc, step;
        logic tick;
        if (r) begin
            m_state = M_PAUSED; m_field = 0; m_cs = 0; m_pre = 0;
            m_cyc = 0; m_ticks = 0; m_acnt = 0;
            return;
        end
        tick      = (m_cyc % TICK_DIV) == TICK_DIV - 1;
        old_state = m_state;
        old_cs    = m_cs;
        hh = m_cs / 360000;
        mm = (m_cs / 6000) % 60;
        ss = (m_cs / 100) % 60;
        cc = m_cs % 100;
        if (sm) begin
            if (old_state != M_SET) begin
                m_state = M_SET;
                m_cs    = old_cs - cc;
            end else if (clr) begin
                m_cs = 0;
            end else if (sel) begin
                m_field = (m_field + 1) % 3;
            end else if (up != dn) begin
                step = up ? 1 : -1;
                case (m_field)
                    0:       ss = (ss + step + 60) % 60;
                    1:       mm = (mm + step + 60) % 60;
                    default: hh = (hh + step + HOUR_MAX + 1) % (HOUR_MAX + 1);
                endcase
                m_cs = hh * 360000 + mm * 6000 + ss * 100 + cc;
            end
        end else begin
            case (old_state)
                M_SET: m_state = M_PAUSED;
                M_PAUSED: begin
                    if (clr) m_cs = 0;
                    else if (sel && m_cs != 0) m_state = M_RUN;
                end
                M_RUN: begin
                    if (clr) begin
                        m_cs = 0; m_state = M_PAUSED;
                    end else if (sel) begin
                        m_state = M_PAUSED;
                    end else if (tick) begin
                        m_cs = m_cs - 1;
                        if (m_cs == 0) m_state = M_EXPIRED;
                    end
                end
                default: begin
                    if (sel || up || dn || clr || (tick && m_acnt == ALARM_TICKS - 1)) begin
                        m_state = M_PAUSED;
                        m_cs    = m_pre * 100;
                    end else if (tick) begin
                        m_acnt = m_acnt + 1;
                    end
                end
            endcase
        end
        if (old_state == M_SET) m_pre = old_cs / 100;
        if (m_state != M_EXPIRED) m_acnt = 0;
        m_cyc = m_cyc + 1;
        if (tick) m_ticks = m_ticks + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic sm, input logic sel,
                                 input logic up, input logic dn, input logic clr);
        rst            = r;
        bus.set_mode_i = sm;
        bus.select_i   = sel;
        bus.up_i       = up;
        bus.down_i     = dn;
        bus.clear_i    = clr;
        @(posedge clk);
        model_step(r, sm, sel, up, dn, clr);
        #1;
        checkOutput("digits", bus.digits_o, to_digits(m_cs));
        checkOutput("flags", {27'd0, bus.running_o, bus.alarm_o, bus.blink_hr_o,
                              bus.blink_min_o, bus.blink_sec_o}, exp_flags());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, sm_level, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse(input logic sel, input logic up, input logic dn, input logic clr);
        applyStimulus(1'b0, sm_level, sel, up, dn, clr);
    endtask

    task automatic wait_alarm(input logic target, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && bus.alarm_o !== target; i++) idle(1);
        checkOutput(tag, {31'd0, bus.alarm_o}, {31'd0, target});
    endtask

    initial begin
        bus.set_mode_i = 1'b0;
        bus.select_i   = 1'b0;
        bus.up_i       = 1'b0;
        bus.down_i     = 1'b0;
        bus.clear_i    = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_digits", bus.digits_o, 32'h0);

        // Field editing and wrap-around in SET.
        sm_level = 1'b1;
        idle(1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        pulse(0, 1, 0, 0);
        idle(8);
        checkOutput("set_min02", bus.digits_o, 32'h00020000);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        checkOutput("hr_wrap_down", bus.digits_o, 32'h23020000);
        pulse(0, 1, 0, 0);
        checkOutput("hr_wrap_up", bus.digits_o, 32'h00020000);
        pulse(0, 1, 1, 0);
        checkOutput("up_down_both", bus.digits_o, 32'h00020000);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        checkOutput("sec_wrap_down", bus.digits_o, 32'h00025900);
        pulse(0, 0, 0, 1);
        pulse(0, 1, 0, 0);
        checkOutput("set_1s", bus.digits_o, 32'h00000100);

        // Countdown to expiry, then manual reload.
        sm_level = 1'b0;
        idle(1);
        pulse(1, 0, 0, 0);
        checkOutput("run_on", {31'd0, bus.running_o}, 32'd1);
        for (int i = 0; i < 2 * TICK_DIV && m_cs == 100; i++) idle(1);
        checkOutput("first_tick", bus.digits_o, 32'h00000099);
        wait_alarm(1'b1, 150 * TICK_DIV, "expire");
        checkOutput("expired_zero", bus.digits_o, 32'h0);
        pulse(0, 1, 0, 0);
        checkOutput("reload_alarm", {31'd0, bus.alarm_o}, 32'd0);
        checkOutput("reload_digits", bus.digits_o, 32'h00000100);

        // Second expiry left alone until the alarm period reloads it.
        pulse(1, 0, 0, 0);
        wait_alarm(1'b1, 150 * TICK_DIV, "expire2");
        wait_alarm(1'b0, (ALARM_TICKS + 2) * TICK_DIV, "alarm_timeout");
        checkOutput("auto_reload", bus.digits_o, 32'h00000100);

        // select_i beats a coincident tick in RUN.
        sm_level = 1'b1;
        idle(1);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        sm_level = 1'b0;
        idle(1);
        pulse(1, 0, 0, 0);
        for (int i = 0; i < TICK_DIV && (m_cyc % TICK_DIV) != TICK_DIV - 1; i++) idle(1);
        pulse(1, 0, 0, 0);
        checkOutput("sel_vs_tick", bus.digits_o, 32'h00010000);
        checkOutput("sel_pause", {31'd0, bus.running_o}, 32'd0);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        checkOutput("zero_no_run", {31'd0, bus.running_o}, 32'd0);

        // Reset in the middle of RUN.
        sm_level = 1'b1;
        idle(1);
        pulse(0, 1, 0, 0);
        sm_level = 1'b0;
        idle(1);
        pulse(1, 0, 0, 0);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_digits", bus.digits_o, 32'h0);
        checkOutput("rst_flags", {27'd0, bus.running_o, bus.alarm_o, bus.blink_hr_o,
                                  bus.blink_min_o, bus.blink_sec_o}, 32'd0);
        sm_level = 1'b1;
        idle(1);
        pulse(0, 1, 0, 0);
        checkOutput("rst_field_sec", bus.digits_o, 32'h00000100);
        sm_level = 1'b0;
        idle(2);

        // Random button traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic r, sel, up, dn, clr;
            if ($urandom_range(0, 49) == 0) sm_level = ~sm_level;
            r   = ($urandom_range(0, 599) == 0);
            sel = ($urandom_range(0, 24) == 0);
            up  = ($urandom_range(0, 7) == 0);
            dn  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 99) == 0);
            applyStimulus(r, sm_level, sel, up, dn, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Parametrised successor to the stopwatch timer: a BCD hh:mm:ss.cc countdown timer with field-by-field set mode, run/pause, an expiry alarm and automatic reload of the last programmed value. It sits between the debounced button/switch front end and the 7-segment digit drivers. It is sized so that simulation can use a small prescaler and the board build uses the real one.

Parameters:
TICK_DIV, 500000, clk_i cycles per centisecond tick (must be >= 2)
BLINK_TICKS, 25, centisecond ticks per blink-phase toggle
HOUR_MAX, 23, maximum hour value (BCD, <= 99)
ALARM_TICKS, 500, centisecond ticks the alarm stays asserted before auto-reload

Ports:
clk_i  input  1  system clock
reset_i  input  1  synchronous, active-high reset
set_mode_i  input  1  level: 1 = SET mode, 0 = run/pause operation
select_i  input  1  one-cycle pulse: next field (SET) / start-pause toggle (otherwise)
up_i  input  1  one-cycle pulse: increment selected field (SET)
down_i  input  1  one-cycle pulse: decrement selected field (SET)
clear_i  input  1  one-cycle pulse: zero the count
digits_o  output  32  BCD {decahr,hr,decamin,min,decasec,sec,decisec,centisec}, 4 bits each
blink_sec_o / blink_min_o / blink_hr_o  output  1 each  blank-request for the field
running_o  output  1  1 in RUN
alarm_o  output  1  1 in EXPIRED

Behaviour:
- One clock, synchronous active-high reset_i. On reset: state PAUSED, count 00:00:00.00, preload 00:00:00, field = SEC, prescaler and blink counters 0, all outputs 0.
- Prescaler is free-running 0..TICK_DIV-1; tick = 1 for one cycle when it equals TICK_DIV-1.
- Blink phase toggles every BLINK_TICKS ticks.
- States: SET, PAUSED, RUN, EXPIRED.
- Input priority per cycle: reset_i > set_mode_i > clear_i > select_i > up_i > down_i. If up_i and down_i are both 1, the field does not change.
- Any state with set_mode_i=1 -> SET. On entry, centiseconds are forced to 00 and the alarm clears.
- SET:
  - select_i rotates the field SEC->MIN->HR->SEC.
  - up_i/down_i change the field with wrap: sec/min 59<->00; hr HOUR_MAX<->00.
  - clear_i zeroes hh:mm:ss.
  - Each cycle in SET, preload <= hh:mm:ss.
  - set_mode_i falling (1->0) -> PAUSED.
- PAUSED: select_i -> RUN only if count != 0 (otherwise ignored). clear_i zeroes the count.
- RUN: on each tick, decrement the count by 0.01 s with BCD borrow chain cc 00->99, ss 00->59, mm 00->59, hh decrement. select_i -> PAUSED (the count holds). clear_i -> count 0, PAUSED.
- Expiry: the decrement that yields 00:00:00.00 also moves to EXPIRED in the same cycle. The count displays zero.
- EXPIRED:
  - alarm_o = 1.
  - Any of select_i/up_i/down_i/clear_i, or ALARM_TICKS ticks elapsed -> PAUSED with count <= preload.cc=00, and the alarm counter clears.
- A tick coinciding with select_i in RUN: select_i wins, no decrement that cycle.
- Outputs are registered (one-cycle latency from the causing edge).
- running_o = (state==RUN).
- blink_x_o = blink_phase & (state==SET) & (field==x). In EXPIRED, all three blink_x_o = blink_phase.
- All digit fields stay in legal BCD range at all times. Illegal values are never produced.
- reset_i mid-RUN/EXPIRED restores the full reset state on the next edge.

Test Plan:
- TICK_DIV=2, BLINK_TICKS=2: reset, then set_mode_i=1, select_i x1, up_i x2 -> digits_o=0x00020000, blink_min_o toggles every 4 cycles, blink_sec_o=0.
- In SET at sec=00, down_i -> sec=59. In HR at 23, up_i -> 00 (HOUR_MAX=23).
- Program 00:00:01, set_mode_i=0, select_i -> running_o=1; after 100 ticks digits_o=0; the same cycle has alarm_o=1 (next edge) and the intermediate count reads 00:00:00.99 after 1 tick.
- In EXPIRED, pulse up_i -> alarm_o=0, state PAUSED, digits_o=0x00000100. With no press, the alarm self-clears after ALARM_TICKS ticks with the same reload.
- In RUN at 00:01:00.00, select_i on a tick cycle -> count holds 00:01:00.00, running_o=0. In PAUSED with count 0, select_i -> running_o stays 0.
- reset_i asserted mid-RUN -> next edge: digits_o=0, running_o=0, alarm_o=0, all blinks 0. The following SET starts at field SEC.
